lenet_mac_pipe: RTL
===================

# lenet_mac_pipe

Parametrised, pipelined fixed-point multiply-accumulate unit for the LeNet accelerator datapath. It is the next generation of the single-stage 32s×15ns multiplier. It adds configurable multiplier depth, a selectable signedness for operand 1, stream accumulation framed by first/last flags, rounded fixed-point rescaling, and output saturation. It sits between the weight/feature-map buffers and the activation/pooling stage and produces one result per kernel dot product.

## Interface
- DIN0_WIDTH, 16: operand 0 width; always signed.
- DIN1_WIDTH, 16: operand 1 width.
- DIN1_SIGNED, 0: 0 = din1 zero-extended (unsigned); 1 = din1 signed.
- DOUT_WIDTH, 16: signed result width.
- NUM_STAGE, 2: product register stages, ≥1.
- ACC_GUARD, 8: accumulator guard bits; ACC_WIDTH = DIN0_WIDTH+DIN1_WIDTH+1+ACC_GUARD.
- FRAC_SHIFT, 8: arithmetic right shift applied to the accumulator before saturation; 0 ≤ FRAC_SHIFT < ACC_WIDTH.
- clk  in  1  clock; all registers update on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes every register.
- in_valid  in  1  operand pair valid.
- in_first  in  1  first term of a dot product; qualified by in_valid.
- in_last  in  1  last term; qualified by in_valid; may coincide with in_first.
- din0  in  DIN0_WIDTH  signed operand.
- din1  in  DIN1_WIDTH  operand, signedness per DIN1_SIGNED.
- out_valid  out  1  dout/sat valid.
- dout  out  DOUT_WIDTH  rounded, saturated result.
- sat  out  1  saturation occurred for this result.

## Operation
- Product: P = din0 × ext(din1), where ext is zero- or sign-extension by one bit. P is DIN0_WIDTH+DIN1_WIDTH+1 bits, signed. P enters a NUM_STAGE-deep register chain. valid/first/last travel alongside P in matching sideband registers.
- Accumulate stage, when the chain output is valid:
  - first = 1: acc ← sext(P).
  - first = 0: acc ← acc + sext(P).
  - Not valid: acc holds.
  - ACC_GUARD guarantees no wrap for ≤ 2^ACC_GUARD terms. Longer streams wrap modulo 2^ACC_WIDTH and are not flagged.
  - The accumulate stage forwards valid & last as a one-bit "done".
- Output stage, on done:
  - r = (acc_next + (FRAC_SHIFT>0 ? 2^(FRAC_SHIFT−1) : 0)) >>> FRAC_SHIFT. This is round-half-up, i.e. toward +∞. The add is computed at ACC_WIDTH+1 bits.
  - r is clamped to [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1]. sat = 1 iff the clamp was applied.
  - dout and sat are registered. out_valid = 1 for exactly one ce-qualified cycle.
  - dout/sat hold their last value when out_valid = 0.
- Bubbles (in_valid = 0) inside a stream are allowed; acc holds across them.
- A first without a preceding last discards the partial sum; the new stream starts cleanly.
- Terms arriving before any first accumulate onto the current acc, which is 0 after reset.
- in_first/in_last are ignored when in_valid = 0.

## Timing
- With ce = 1 every cycle, latency from an in_valid & in_last cycle to out_valid is NUM_STAGE+2 cycles.
- Throughput: one term per cycle; back-to-back single-term streams give back-to-back results.
- ce = 0 stalls every register, including out_valid. A pulse present when ce falls persists until the next ce = 1 edge. The effective latency grows by exactly the number of ce = 0 cycles.
- Reset clears, asynchronously:
  - all sideband valid/first/last registers;
  - acc, dout, sat and out_valid, all to 0.
  - In-flight terms are lost. Reset mid-stream yields no output for that stream.

## Structure
- Shared package lenet_arith_pkg holds:
  - the ACC_WIDTH derivation function;
  - the saturate function (width-generic clamp returning value and flag);
  - the round-half-up shift function.
- Sub-module lenet_mul_pipe: signed × selectable-sign multiplier with an NUM_STAGE register chain, ce, and sideband passthrough. It is reusable by the successor of the plain multiplier.
- Top level lenet_mac_pipe: accumulate stage, output stage and control.

## Test plan
All scenarios use default parameters unless stated otherwise.
- Single term: din0 = 0x0100, din1 = 0x0200, first = last = 1 → out_valid at cycle +4; dout = 0x0200, sat = 0.
- Three-term stream, each term din0 = din1 = 0x0100, with a one-cycle bubble after term 2 → one out_valid; dout = 0x0300.
- Saturation:
  - din0 = 0x7FFF, din1 = 0xFFFF (unsigned), single term → dout = 0x7FFF, sat = 1.
  - din0 = 0x8000, din1 = 0xFFFF → dout = 0x8000, sat = 1.
  - Rerun with DIN1_SIGNED = 1: din0 = 0x8000, din1 = 0xFFFF → 32768 >>> 8 = 128; dout = 0x0080, sat = 0.
- Rounding:
  - din0 = 1, din1 = 128 → 1.
  - din0 = 1, din1 = 127 → 0.
  - din0 = −1, din1 = 128 → 0.
  - din0 = −1, din1 = 129 → −1.
- ce stall: drop ce for 3 cycles while a single term is in the pipe → out_valid appears at cycle +7 with unchanged dout; the pulse stays high across any ce = 0 cycles that follow it.
- Reset mid-stream: after 2 of 4 terms, pulse reset → out_valid, dout and sat read 0 immediately, with no result for that stream. A following single term 0x0100 × 0x0100 → dout = 0x0100.

Source files
------------

// File: rtl/lenet_arith_pkg.sv
// Shared fixed-point helpers for the LeNet datapath: accumulator sizing,
// round-half-up rescaling and width-generic saturation.
package lenet_arith_pkg;

  // Working width for the generic helpers; wide enough for any realistic accumulator.
  localparam int unsigned MAXW = 128;

  typedef struct packed {
    logic signed [MAXW-1:0] val;
    logic                   sat;
  } sat_t;

  function automatic int unsigned acc_width(input int unsigned d0_w,
                                            input int unsigned d1_w,
                                            input int unsigned guard);
    return d0_w + d1_w + 1 + guard;
  endfunction

  // Arithmetic shift right with +half-LSB bias, i.e. round toward +inf on ties.
  function automatic logic signed [MAXW-1:0] round_shift(input logic signed [MAXW-1:0] x,
                                                         input int unsigned            sh);
    logic signed [MAXW-1:0] bias;
    bias = '0;
    if (sh > 0) bias = MAXW'(1) << (sh - 1);
    return (x + bias) >>> sh;
  endfunction

  function automatic sat_t saturate(input logic signed [MAXW-1:0] x,
                                    input int unsigned            w);
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    sat_t                   res;
    hi      = (MAXW'(1) << (w - 1)) - MAXW'(1);
    lo      = ~hi;
    res.val = x;
    res.sat = 1'b0;
    if (x > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (x < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lenet_mul_pipe.sv
// Signed x selectable-sign multiplier feeding a NUM_STAGE-deep register chain,
// with valid/first/last sideband carried alongside the product.
module lenet_mul_pipe #(
  parameter int unsigned DIN0_WIDTH  = 16,
  parameter int unsigned DIN1_WIDTH  = 16,
  parameter bit          DIN1_SIGNED = 1'b0,
  parameter int unsigned NUM_STAGE   = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ce,
  input  logic                                   in_valid,
  input  logic                                   in_first,
  input  logic                                   in_last,
  input  logic [DIN0_WIDTH-1:0]                  din0,
  input  logic [DIN1_WIDTH-1:0]                  din1,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH:0]  p_out,
  output logic                                   p_valid,
  output logic                                   p_first,
  output logic                                   p_last
);

  localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH + 1;

  logic                 b_sign;
  logic [PW-1:0]        a_x;
  logic [PW-1:0]        b_x;
  logic signed [PW-1:0] prod_d;

  logic signed [PW-1:0] prod_q  [NUM_STAGE];
  logic                 vld_q   [NUM_STAGE];
  logic                 first_q [NUM_STAGE];
  logic                 last_q  [NUM_STAGE];

  // Both operands widened to the full product width so the low PW bits are exact.
  assign b_sign = DIN1_SIGNED ? din1[DIN1_WIDTH-1] : 1'b0;
  assign a_x    = {{(DIN1_WIDTH+1){din0[DIN0_WIDTH-1]}}, din0};
  assign b_x    = {{DIN0_WIDTH{b_sign}}, b_sign, din1};
  assign prod_d = $signed(a_x) * $signed(b_x);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_STAGE); i++) begin
        prod_q[i]  <= '0;
        vld_q[i]   <= 1'b0;
        first_q[i] <= 1'b0;
        last_q[i]  <= 1'b0;
      end
    end else if (ce) begin
      prod_q[0]  <= prod_d;
      vld_q[0]   <= in_valid;
      first_q[0] <= in_valid & in_first;
      last_q[0]  <= in_valid & in_last;
      for (int i = 1; i < int'(NUM_STAGE); i++) begin
        prod_q[i]  <= prod_q[i-1];
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign p_out   = prod_q[NUM_STAGE-1];
  assign p_valid = vld_q[NUM_STAGE-1];
  assign p_first = first_q[NUM_STAGE-1];
  assign p_last  = last_q[NUM_STAGE-1];

endmodule

// File: rtl/lenet_mac_pipe.sv
// Pipelined fixed-point MAC: multiplier chain, first/last framed accumulation,
// round-half-up rescale and saturating registered output.
module lenet_mac_pipe
  import lenet_arith_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH  = 16,
  parameter int unsigned DIN1_WIDTH  = 16,
  parameter bit          DIN1_SIGNED = 1'b0,
  parameter int unsigned DOUT_WIDTH  = 16,
  parameter int unsigned NUM_STAGE   = 2,
  parameter int unsigned ACC_GUARD   = 8,
  parameter int unsigned FRAC_SHIFT  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [DIN0_WIDTH-1:0]        din0,
  input  logic [DIN1_WIDTH-1:0]        din1,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat
);

  localparam int unsigned PW        = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int unsigned ACC_WIDTH = acc_width(DIN0_WIDTH, DIN1_WIDTH, ACC_GUARD);

  logic signed [PW-1:0]        p;
  logic                        p_valid;
  logic                        p_first;
  logic                        p_last;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        done_q, done_d;
  logic                        out_valid_q;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                        sat_q, sat_d;

  logic signed [MAXW-1:0]      acc_ext;
  logic signed [MAXW-1:0]      rounded;
  sat_t                        clamp;
  logic                        unused_clamp_hi;

  lenet_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DIN1_SIGNED(DIN1_SIGNED),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .in_valid(in_valid),
    .in_first(in_first),
    .in_last (in_last),
    .din0    (din0),
    .din1    (din1),
    .p_out   (p),
    .p_valid (p_valid),
    .p_first (p_first),
    .p_last  (p_last)
  );

  // Accumulate: first restarts the sum, later terms add, bubbles hold.
  always_comb begin
    acc_d  = acc_q;
    done_d = p_valid & p_last;
    if (p_valid) begin
      if (p_first) acc_d = ACC_WIDTH'(p);
      else         acc_d = acc_q + ACC_WIDTH'(p);
    end
  end

  // Rescale the completed sum registered in acc_q and clamp to the output range.
  always_comb begin
    acc_ext = MAXW'(acc_q);
    rounded = round_shift(acc_ext, FRAC_SHIFT);
    clamp   = saturate(rounded, DOUT_WIDTH);
    dout_d  = clamp.val[DOUT_WIDTH-1:0];
    sat_d   = clamp.sat;
  end

  assign unused_clamp_hi = ^clamp.val[MAXW-1:DOUT_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      done_q      <= done_d;
      out_valid_q <= done_q;
      if (done_q) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule
